error_stats_monitor: RTL and testbench

ERROR_STATS_MONITOR -- requirements
Module: error_stats_monitor

---
 rtl/error_stats_monitor.sv | 80 ++++++++
 tb/tb_error_stats_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/error_stats_monitor.sv
// error_stats_monitor: windowed error-distance statistics for an approximate adder against its exact reference.
module error_stats_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] window_i,
    input  logic             valid_i,
    input  logic [WIDTH:0]   exact_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [WIDTH:0]   max_ed_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic             sat_o
);
    localparam int SW = (ACC_W > WIDTH + 1 ? ACC_W : WIDTH + 1) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] win, acc_cnt;
    logic s1_valid, accept, take, last, clamp;
    logic [WIDTH:0] s1_ed, ed;
    logic [SW-1:0] sum_wide;
    always_comb begin
        accept = state == IDLE && start_i && window_i != '0;
        take = state == RUN && valid_i;
        last = take && (acc_cnt + CNT_W'(1)) == win;
        ed = exact_i >= approx_i ? exact_i - approx_i : approx_i - exact_i;
        // widened so the sum can exceed ACC_W and be detected as a clamp
        sum_wide = SW'(sum_ed_o) + SW'(s1_ed);
        clamp = sum_wide > SW'({ACC_W{1'b1}});
        state_nx = state == IDLE ? (accept ? RUN : IDLE) :
                   state == RUN ? (last ? DRAIN : RUN) :
                   state == DRAIN ? DONE : IDLE;
    end
    assign busy_o = state == RUN || state == DRAIN;
    assign done_o = state == DONE;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win <= '0;
            acc_cnt <= '0;
            s1_valid <= 1'b0;
            s1_ed <= '0;
            sample_cnt_o <= '0;
            err_cnt_o <= '0;
            max_ed_o <= '0;
            sum_ed_o <= '0;
            sat_o <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_ed <= ed;
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (accept) begin
                win <= window_i;
                acc_cnt <= '0;
                sample_cnt_o <= '0;
                err_cnt_o <= '0;
                max_ed_o <= '0;
                sum_ed_o <= '0;
                sat_o <= 1'b0;
            end else if (s1_valid) begin
                sample_cnt_o <= sample_cnt_o + CNT_W'(1);
                err_cnt_o <= s1_ed != '0 ? err_cnt_o + CNT_W'(1) : err_cnt_o;
                max_ed_o <= s1_ed > max_ed_o ? s1_ed : max_ed_o;
                sum_ed_o <= clamp ? '1 : sum_wide[ACC_W-1:0];
                sat_o <= sat_o | clamp;
            end
        end
    end
endmodule

// File: tb/tb_error_stats_monitor.sv
// tb_error_stats_monitor: directed vectors with hand-computed statistics for error_stats_monitor.
module tb_error_stats_monitor;
    localparam int WIDTH = 16;
    localparam int CNT_W = 16;
    localparam int ACC_W = 8;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic [CNT_W-1:0] window_i = '0;
    logic valid_i = 1'b0;
    logic [WIDTH:0] exact_i = '0;
    logic [WIDTH:0] approx_i = '0;
    logic busy_o, done_o, sat_o;
    logic [CNT_W-1:0] sample_cnt_o, err_cnt_o;
    logic [WIDTH:0] max_ed_o;
    logic [ACC_W-1:0] sum_ed_o;
    int n_cmp = 0;
    int n_err = 0;
    int done_seen;
    error_stats_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .window_i(window_i),
        .valid_i(valid_i), .exact_i(exact_i), .approx_i(approx_i),
        .busy_o(busy_o), .done_o(done_o), .sample_cnt_o(sample_cnt_o),
        .err_cnt_o(err_cnt_o), .max_ed_o(max_ed_o), .sum_ed_o(sum_ed_o), .sat_o(sat_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic start(input int w);
        start_i = 1'b1;
        window_i = CNT_W'(w);
        step();
        start_i = 1'b0;
        window_i = '0;
    endtask
    task automatic sample(input int e, input int a);
        valid_i = 1'b1;
        exact_i = 17'(e);
        approx_i = 17'(a);
        step();
        valid_i = 1'b0;
    endtask
    task automatic stats(input string tag, input int s, input int e, input int m, input int sum, input int sat);
        chk({tag, "_samples"}, 32'(sample_cnt_o), 32'(s));
        chk({tag, "_errs"}, 32'(err_cnt_o), 32'(e));
        chk({tag, "_max"}, 32'(max_ed_o), 32'(m));
        chk({tag, "_sum"}, 32'(sum_ed_o), 32'(sum));
        chk({tag, "_sat"}, 32'(sat_o), 32'(sat));
    endtask
    initial begin
        step();
        step();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        stats("rst", 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        // exact match, start right after reset release
        start(4);
        chk("start_after_rst", 32'(busy_o), 1);
        for (int i = 0; i < 4; i++) sample('h0ABCD, 'h0ABCD);
        chk("exact_drain_busy", 32'(busy_o), 1);
        chk("exact_drain_done", 32'(done_o), 0);
        step();
        chk("exact_done", 32'(done_o), 1);
        stats("exact", 4, 0, 0, 0, 0);
        step();
        chk("exact_idle_done", 32'(done_o), 0);
        chk("exact_idle_busy", 32'(busy_o), 0);
        // mixed errors, two-cycle latency into the statistics
        start(3);
        sample('h10000, 'h0FFF0);
        chk("mix_lat_s1", 32'(sample_cnt_o), 0);
        sample(5, 7);
        chk("mix_lat_cnt", 32'(sample_cnt_o), 1);
        chk("mix_lat_sum", 32'(sum_ed_o), 16);
        sample(9, 9);
        chk("mix_drain_done", 32'(done_o), 0);
        step();
        chk("mix_done", 32'(done_o), 1);
        stats("mix", 3, 2, 16, 18, 0);
        // gapped valid, then a valid pulse after the window is ignored
        step();
        start(2);
        step();
        sample(3, 3);
        for (int i = 0; i < 3; i++) step();
        sample(3, 3);
        chk("gap_drain_busy", 32'(busy_o), 1);
        step();
        chk("gap_done", 32'(done_o), 1);
        chk("gap_done_busy", 32'(busy_o), 0);
        sample(1, 2);
        step();
        step();
        stats("gap", 2, 0, 0, 0, 0);
        // saturation of the 8-bit accumulator
        start(3);
        sample('h90, 0);
        sample('h90, 0);
        chk("sat_one_sum", 32'(sum_ed_o), 'h90);
        chk("sat_one_flag", 32'(sat_o), 0);
        sample(0, 'h90);
        chk("sat_two_sum", 32'(sum_ed_o), 'hFF);
        chk("sat_two_flag", 32'(sat_o), 1);
        step();
        chk("sat_done", 32'(done_o), 1);
        stats("sat", 3, 3, 'h90, 'hFF, 1);
        step();
        // zero window ignored, start during RUN ignored
        start(0);
        chk("zero_win_busy", 32'(busy_o), 0);
        step();
        stats("zero_win", 3, 3, 'h90, 'hFF, 1);
        start(2);
        stats("restart", 0, 0, 0, 0, 0);
        sample(10, 4);
        start(5);
        chk("run_start_busy", 32'(busy_o), 1);
        sample(4, 10);
        step();
        chk("run_start_done", 32'(done_o), 1);
        stats("run_start", 2, 2, 6, 12, 0);
        step();
        // reset mid-window
        start(5);
        sample(1, 0);
        sample(2, 0);
        step();
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 0);
        stats("mid_rst", 0, 0, 0, 0, 0);
        step();
        rst_i = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done_o) done_seen++;
        end
        chk("mid_rst_no_done", 32'(done_seen), 0);
        start(1);
        sample(7, 4);
        step();
        chk("post_rst_done", 32'(done_o), 1);
        stats("post_rst", 1, 1, 3, 3, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
